// File: rtl/hazard_tracker_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hazard_tracker_pkg
// Purpose  : Shared types and constants for the pipeline hazard tracker:
//            register-index width, the zero register, the tracked-producer
//            entry struct and the stall-counter width.
// Config   : HAZARD_TRACKER_STATS_EN (consumed by hazard_tracker only)
// Revision : 1.0 - initial release
// ============================================================================
package hazard_tracker_pkg;

  localparam int REG_W   = 5;
  localparam int STATS_W = 16;

  localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

  // One tracked producer: does it exist, does it write a register,
  // is it a load, and which register does it write.
  typedef struct packed {
    logic             valid;
    logic             regWrite;
    logic             memToReg;
    logic [REG_W-1:0] dest;
  } hz_entry_t;

  localparam hz_entry_t ENTRY_BUBBLE = '0;

  // A producer feeds a Decode source only if it writes a real register
  // (never r0) and that register is one of the two sources.
  function automatic logic src_hit(input logic [REG_W-1:0] dest,
                                   input logic [REG_W-1:0] rs,
                                   input logic [REG_W-1:0] rt);
    return (dest != REG_ZERO) && ((dest == rs) || (dest == rt));
  endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_tracker_stage_reg.sv
`default_nettype none
// ============================================================================
// Module   : hazard_stage_reg
// Purpose  : One tracked pipeline entry with load, hold, bubble and clear.
//            Priority: reset clear > hold > bubble > load.
// Ports    : clk    - rising-edge clock
//            rst    - synchronous active-low reset (clears the entry)
//            hold   - keep the current contents
//            bubble - load an all-zero entry instead of d
//            d      - next entry contents
//            q      - current entry contents
// Revision : 1.0 - initial release
// ============================================================================
module hazard_stage_reg
  import hazard_tracker_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      hold,
  input  logic      bubble,
  input  hz_entry_t d,
  output hz_entry_t q
);

  hz_entry_t entry_q;
  hz_entry_t entry_d;

  always_comb begin
    entry_d = entry_q;
    if (!hold) begin
      entry_d = bubble ? ENTRY_BUBBLE : d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      entry_q <= ENTRY_BUBBLE;
    end else begin
      entry_q <= entry_d;
    end
  end

  assign q = entry_q;

endmodule
`default_nettype wire

// File: rtl/hazard_tracker.sv
`default_nettype none
// ============================================================================
// Module   : hazard_tracker
// Purpose  : Tracks the producers in Execute, Memory and Writeback and raises
//            load-use and branch-operand stalls for the instruction in Decode.
// Ports    : clk, rst (sync active-low)
//            rsD, rtD, writeRegD       - Decode source/destination registers
//            validD, regWriteD,
//            memToRegD, branchD        - Decode control
//            stallExt                  - external freeze of the whole pipeline
//            stallF, stallD, flushE    - hazard response (combinational)
//            writeRegE/M/W,
//            regWriteE/M/W             - tracked producers for forwarding
//            stallCount                - saturating hazard-stall counter
//                                        (only with the macro below)
// Config   : HAZARD_TRACKER_STATS_EN - adds stallCount and its counter
// Revision : 1.0 - initial release
// ============================================================================
module hazard_tracker
  import hazard_tracker_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] rsD,
  input  logic [REG_W-1:0] rtD,
  input  logic             validD,
  input  logic             regWriteD,
  input  logic             memToRegD,
  input  logic             branchD,
  input  logic [REG_W-1:0] writeRegD,
  input  logic             stallExt,
  output logic             stallF,
  output logic             stallD,
  output logic             flushE,
  output logic [REG_W-1:0] writeRegE,
  output logic [REG_W-1:0] writeRegM,
  output logic [REG_W-1:0] writeRegW,
  output logic             regWriteE,
  output logic             regWriteM,
  output logic             regWriteW
`ifdef HAZARD_TRACKER_STATS_EN
  ,
  output logic [STATS_W-1:0] stallCount
`endif
);

  hz_entry_t ent_e;
  hz_entry_t ent_m;
  hz_entry_t ent_w;
  hz_entry_t ent_d;

  logic load_use;
  logic branch_haz;
  logic hazard;

  // Control bits of a bubble in Decode must never reach the tracked state.
  always_comb begin
    ent_d          = ENTRY_BUBBLE;
    ent_d.valid    = validD;
    ent_d.regWrite = regWriteD & validD;
    ent_d.memToReg = memToRegD & validD;
    ent_d.dest     = writeRegD;
  end

  always_comb begin
    load_use = validD & ent_e.valid & ent_e.regWrite & ent_e.memToReg &
               src_hit(ent_e.dest, rsD, rtD);
    // A branch resolves in Decode, so it needs its operand before any
    // forwarding from Execute can help; a load in Memory is also too late.
    branch_haz = validD & branchD &
                 ((ent_e.valid & ent_e.regWrite &
                   src_hit(ent_e.dest, rsD, rtD)) |
                  (ent_m.valid & ent_m.regWrite & ent_m.memToReg &
                   src_hit(ent_m.dest, rsD, rtD)));
    hazard = load_use | branch_haz;
  end

  assign stallF = hazard | stallExt;
  assign stallD = hazard | stallExt;
  // Under an external freeze nothing advances, so no bubble is injected.
  assign flushE = hazard & ~stallExt;

  hazard_stage_reg u_stage_e (
    .clk    (clk),
    .rst    (rst),
    .hold   (stallExt),
    .bubble (flushE),
    .d      (ent_d),
    .q      (ent_e)
  );

  hazard_stage_reg u_stage_m (
    .clk    (clk),
    .rst    (rst),
    .hold   (stallExt),
    .bubble (1'b0),
    .d      (ent_e),
    .q      (ent_m)
  );

  hazard_stage_reg u_stage_w (
    .clk    (clk),
    .rst    (rst),
    .hold   (stallExt),
    .bubble (1'b0),
    .d      (ent_m),
    .q      (ent_w)
  );

  assign writeRegE = ent_e.dest;
  assign writeRegM = ent_m.dest;
  assign writeRegW = ent_w.dest;
  assign regWriteE = ent_e.valid & ent_e.regWrite;
  assign regWriteM = ent_m.valid & ent_m.regWrite;
  assign regWriteW = ent_w.valid & ent_w.regWrite;

`ifdef HAZARD_TRACKER_STATS_EN
  logic [STATS_W-1:0] stall_cnt_q;
  logic [STATS_W-1:0] stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (hazard && !stallExt && (stall_cnt_q != {STATS_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + {{(STATS_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stallCount = stall_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_tracker.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_tracker
// Purpose  : Self-checking bench for hazard_tracker: directed scenarios and a
//            randomized run against a behavioural model of the three tracked
//            producers.
// Config   : HAZARD_TRACKER_STATS_EN - also checks stallCount
// Revision : 1.0 - initial release
// ============================================================================
module tb_hazard_tracker;

  logic       clk;
  logic       rst;
  logic [4:0] rsD, rtD, writeRegD;
  logic       validD, regWriteD, memToRegD, branchD, stallExt;
  logic       stallF, stallD, flushE;
  logic [4:0] writeRegE, writeRegM, writeRegW;
  logic       regWriteE, regWriteM, regWriteW;
`ifdef HAZARD_TRACKER_STATS_EN
  logic [15:0] stallCount;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  hazard_tracker dut (
    .clk       (clk),
    .rst       (rst),
    .rsD       (rsD),
    .rtD       (rtD),
    .validD    (validD),
    .regWriteD (regWriteD),
    .memToRegD (memToRegD),
    .branchD   (branchD),
    .writeRegD (writeRegD),
    .stallExt  (stallExt),
    .stallF    (stallF),
    .stallD    (stallD),
    .flushE    (flushE),
    .writeRegE (writeRegE),
    .writeRegM (writeRegM),
    .writeRegW (writeRegW),
    .regWriteE (regWriteE),
    .regWriteM (regWriteM),
    .regWriteW (regWriteW)
`ifdef HAZARD_TRACKER_STATS_EN
    ,
    .stallCount(stallCount)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural model: list of producers [E, M, W] --------
  typedef struct {
    bit       v;
    bit       rw;
    bit       ld;
    bit [4:0] dst;
  } ent_t;

  ent_t m[3];
  int   m_cnt;

  function automatic bit feeds(input bit [4:0] d);
    return (d != 0) && (d == rsD || d == rtD);
  endfunction

  function automatic bit exp_lu();
    return validD && m[0].v && m[0].rw && m[0].ld && feeds(m[0].dst);
  endfunction

  function automatic bit exp_bh();
    return validD && branchD &&
           ((m[0].v && m[0].rw && feeds(m[0].dst)) ||
            (m[1].v && m[1].rw && m[1].ld && feeds(m[1].dst)));
  endfunction

  function automatic bit [2:0] exp_stall_vec();
    bit h;
    h = exp_lu() || exp_bh();
    return {h || stallExt, h || stallExt, h && !stallExt};
  endfunction

  // Advance one clock and apply the pipeline rules to the model.
  task automatic clock_edge();
    bit   h;
    ent_t nd;
    @(posedge clk);
    h = exp_lu() || exp_bh();
    if (!rst) m_cnt = 0;
    else if (h && !stallExt && m_cnt < 65535) m_cnt++;
    if (!rst) begin
      for (int i = 0; i < 3; i++) m[i] = '{0, 0, 0, 0};
    end else if (!stallExt) begin
      nd = '{validD, regWriteD && validD, memToRegD && validD, writeRegD};
      m[2] = m[1];
      m[1] = m[0];
      m[0] = h ? '{0, 0, 0, 0} : nd;
    end
    #1;
  endtask

  task automatic set_d(input bit v, input bit rw, input bit ld, input bit br,
                       input bit [4:0] rs, input bit [4:0] rt, input bit [4:0] wr);
    validD = v; regWriteD = rw; memToRegD = ld; branchD = br;
    rsD = rs; rtD = rt; writeRegD = wr;
  endtask

  task automatic do_reset();
    rst = 1'b0; stallExt = 1'b0;
    set_d(0, 0, 0, 0, 0, 0, 0);
    clock_edge();
    rst = 1'b1;
    #1;
  endtask

  // ---------------- scenarios ----------------------------------------------
  task automatic test_reset();
    rst = 1'b0; stallExt = 1'b1;
    set_d(1, 1, 1, 0, 4, 4, 4);
    clock_edge();
    clock_edge();
    rst = 1'b1; stallExt = 1'b0;
    #1;
    n_cmp++; if ({stallF, stallD, flushE} !== 3'b000) begin n_bad++; $display("FAIL reset_stall: got %b want 000", {stallF, stallD, flushE}); end
    n_cmp++; if ({writeRegE, writeRegM, writeRegW} !== 15'd0) begin n_bad++; $display("FAIL reset_writeReg: got %h want 0", {writeRegE, writeRegM, writeRegW}); end
    n_cmp++; if ({regWriteE, regWriteM, regWriteW} !== 3'b000) begin n_bad++; $display("FAIL reset_regWrite: got %b want 000", {regWriteE, regWriteM, regWriteW}); end
`ifdef HAZARD_TRACKER_STATS_EN
    n_cmp++; if (stallCount !== 16'd0) begin n_bad++; $display("FAIL reset_count: got %0d want 0", stallCount); end
`endif
  endtask

  task automatic test_load_use();
    do_reset();
    set_d(1, 1, 1, 0, 1, 2, 5);        // lw r5
    clock_edge();
    set_d(1, 1, 0, 0, 5, 0, 6);        // add r6, r5, r0
    #1;
    n_cmp++; if ({stallF, stallD, flushE} !== 3'b111) begin n_bad++; $display("FAIL lu_stall: got %b want 111", {stallF, stallD, flushE}); end
    clock_edge();
    n_cmp++; if ({stallF, stallD, flushE} !== 3'b000) begin n_bad++; $display("FAIL lu_release: got %b want 000", {stallF, stallD, flushE}); end
    n_cmp++; if ({regWriteM, writeRegM} !== {1'b1, 5'd5}) begin n_bad++; $display("FAIL lu_memstage: got %b/%0d want 1/5", regWriteM, writeRegM); end
    n_cmp++; if ({regWriteE, writeRegE} !== 6'd0) begin n_bad++; $display("FAIL lu_bubble: got %b/%0d want 0/0", regWriteE, writeRegE); end
  endtask

  task automatic test_zero_reg();
    do_reset();
    set_d(1, 1, 1, 0, 1, 2, 0);        // lw r0
    clock_edge();
    set_d(1, 1, 0, 0, 0, 0, 4);
    #1;
    n_cmp++; if ({stallF, stallD, flushE} !== 3'b000) begin n_bad++; $display("FAIL zero_reg: got %b want 000", {stallF, stallD, flushE}); end
    set_d(1, 1, 0, 0, 1, 2, 3);        // add r3 (not a load)
    clock_edge();
    set_d(1, 1, 0, 0, 3, 0, 4);
    #1;
    n_cmp++; if ({stallF, stallD, flushE} !== 3'b000) begin n_bad++; $display("FAIL alu_no_stall: got %b want 000", {stallF, stallD, flushE}); end
  endtask

  task automatic test_branch();
    do_reset();
    set_d(1, 1, 0, 0, 1, 2, 7);        // add r7
    clock_edge();
    set_d(1, 0, 0, 1, 7, 0, 0);        // beq r7, r0
    #1;
    n_cmp++; if ({stallF, stallD, flushE} !== 3'b111) begin n_bad++; $display("FAIL br_alu_stall: got %b want 111", {stallF, stallD, flushE}); end
    clock_edge();
    n_cmp++; if ({stallF, stallD, flushE} !== 3'b000) begin n_bad++; $display("FAIL br_alu_release: got %b want 000", {stallF, stallD, flushE}); end
    set_d(1, 1, 1, 0, 1, 2, 7);        // lw r7
    clock_edge();
    set_d(1, 0, 0, 1, 0, 7, 0);        // beq r0, r7 held for three cycles
    #1;
    n_cmp++; if ({stallF, stallD, flushE} !== 3'b111) begin n_bad++; $display("FAIL br_ld_e: got %b want 111", {stallF, stallD, flushE}); end
    clock_edge();
    n_cmp++; if ({stallF, stallD, flushE} !== 3'b111) begin n_bad++; $display("FAIL br_ld_m: got %b want 111", {stallF, stallD, flushE}); end
    clock_edge();
    n_cmp++; if ({stallF, stallD, flushE} !== 3'b000) begin n_bad++; $display("FAIL br_ld_clear: got %b want 000", {stallF, stallD, flushE}); end
  endtask

  task automatic test_stall_ext();
    do_reset();
    set_d(1, 1, 1, 0, 1, 2, 5);
    clock_edge();
    set_d(1, 1, 0, 0, 5, 0, 6);
    stallExt = 1'b1;
    #1;
    for (int c = 0; c < 3; c++) begin
      n_cmp++; if ({stallF, stallD, flushE} !== 3'b110) begin n_bad++; $display("FAIL ext_stall c%0d: got %b want 110", c, {stallF, stallD, flushE}); end
      n_cmp++; if ({regWriteE, writeRegE, regWriteM} !== {1'b1, 5'd5, 1'b0}) begin n_bad++; $display("FAIL ext_hold c%0d: got %b/%0d/%b want 1/5/0", c, regWriteE, writeRegE, regWriteM); end
      clock_edge();
    end
    stallExt = 1'b0;
    #1;
    n_cmp++; if ({stallF, stallD, flushE} !== 3'b111) begin n_bad++; $display("FAIL ext_release: got %b want 111", {stallF, stallD, flushE}); end
    clock_edge();
    n_cmp++; if ({stallF, regWriteE, writeRegM} !== {2'b00, 5'd5}) begin n_bad++; $display("FAIL ext_resume: got %b/%b/%0d want 0/0/5", stallF, regWriteE, writeRegM); end
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    set_d(1, 1, 1, 0, 1, 2, 9);        // lw r9
    clock_edge();
    set_d(1, 1, 0, 0, 9, 0, 3);
    stallExt = 1'b1;
    clock_edge();
    rst = 1'b0;
    clock_edge();
    rst = 1'b1; stallExt = 1'b0;
    #1;
    n_cmp++; if ({stallF, stallD, flushE} !== 3'b000) begin n_bad++; $display("FAIL rstmid_stall: got %b want 000", {stallF, stallD, flushE}); end
    n_cmp++; if ({writeRegE, writeRegM, writeRegW} !== 15'd0) begin n_bad++; $display("FAIL rstmid_writeReg: got %h want 0", {writeRegE, writeRegM, writeRegW}); end
  endtask

  task automatic test_random();
    bit [2:0] ev;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      rst      = ($urandom_range(0, 39) != 0);
      stallExt = ($urandom_range(0, 5) == 0);
      set_d($urandom_range(0, 7) != 0, $urandom_range(0, 1), $urandom_range(0, 1),
            $urandom_range(0, 2) == 0, 5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
      #1;
      ev = exp_stall_vec();
      n_cmp++; if ({stallF, stallD, flushE} !== ev) begin n_bad++; $display("FAIL rnd_stall c%0d: got %b want %b", c, {stallF, stallD, flushE}, ev); end
      n_cmp++; if ({writeRegE, writeRegM, writeRegW} !== {m[0].dst, m[1].dst, m[2].dst}) begin n_bad++; $display("FAIL rnd_writeReg c%0d: got %h want %h", c, {writeRegE, writeRegM, writeRegW}, {m[0].dst, m[1].dst, m[2].dst}); end
      n_cmp++; if ({regWriteE, regWriteM, regWriteW} !== {m[0].v && m[0].rw, m[1].v && m[1].rw, m[2].v && m[2].rw}) begin n_bad++; $display("FAIL rnd_regWrite c%0d: got %b", c, {regWriteE, regWriteM, regWriteW}); end
`ifdef HAZARD_TRACKER_STATS_EN
      n_cmp++; if (stallCount !== 16'(m_cnt)) begin n_bad++; $display("FAIL rnd_count c%0d: got %0d want %0d", c, stallCount, m_cnt); end
`endif
      clock_edge();
    end
    rst = 1'b1; stallExt = 1'b0;
  endtask

`ifdef HAZARD_TRACKER_STATS_EN
  // Constant lw r5 + branch on r5 in Decode stalls two cycles out of three.
  task automatic test_stats_saturate();
    do_reset();
    set_d(1, 1, 1, 1, 5, 0, 5);
    for (int c = 0; c < 98400; c++) clock_edge();
    n_cmp++; if (stallCount !== 16'hFFFF) begin n_bad++; $display("FAIL stats_sat: got %h want ffff", stallCount); end
    n_cmp++; if (stallCount !== 16'(m_cnt)) begin n_bad++; $display("FAIL stats_model: got %h want %h", stallCount, 16'(m_cnt)); end
  endtask
`endif

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    m_cnt = 0;
    for (int i = 0; i < 3; i++) m[i] = '{0, 0, 0, 0};
    rst = 1'b0; stallExt = 1'b0;
    set_d(0, 0, 0, 0, 0, 0, 0);
    #1;
    test_reset();
    test_load_use();
    test_zero_reg();
    test_branch();
    test_stall_ext();
    test_reset_mid_stall();
    test_random();
`ifdef HAZARD_TRACKER_STATS_EN
    test_stats_saturate();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/hazard_tracker.md
HAZARD_TRACKER -- requirements
Module: hazard_tracker

Interface
REQ-001 The block SHALL have exactly one clock and its reset SHALL be synchronous and active-low. Ports are listed as name, direction, width, meaning.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous active-low reset.
REQ-004 rsD, rtD  input  5 each  source registers of the instruction in Decode.
REQ-005 validD  input  1  Decode holds a real instruction; 0 means a bubble.
REQ-006 regWriteD, memToRegD, branchD  input  1 each  Decode control: writes a register, is a load, or resolves a branch or jr in Decode.
REQ-007 writeRegD  input  5  destination register of the instruction in Decode.
REQ-008 stallExt  input  1  external memory stall that freezes the whole pipeline.
REQ-009 stallF, stallD, flushE  output  1 each  hold Fetch, hold Decode, and insert a bubble into Execute.
REQ-010 writeRegE/M/W  output  5 each, and regWriteE/M/W  output  1 each  tracked producer state, which drives the forwarding unit.

Function
REQ-011 The block SHALL keep three entries, E, M and W. Each entry holds {valid, regWrite, memToReg, dest[4:0]}.
REQ-012 On each clk edge with rst=1 and stallExt=0, entries SHALL shift: D to E, E to M, M to W.
- D to E loads {validD, regWriteD&validD, memToRegD&validD, writeRegD}.
- If flushE=1, E SHALL instead load all zeros (bubble).
REQ-013 When stallExt=1, all three entries SHALL hold their values, and flushE SHALL be 0 regardless of hazards.
REQ-014 Load-use hazard (lu) SHALL be 1 when all of the following hold:
- valid_E, memToReg_E and regWrite_E are 1;
- dest_E != 0;
- dest_E == rsD or dest_E == rtD;
- validD=1.
REQ-015 Branch hazard (bh) SHALL be 1 when validD and branchD are 1 and either:
- (regWrite_E and dest_E != 0 and dest_E in {rsD, rtD}), or
- (memToReg_M and regWrite_M and dest_M != 0 and dest_M in {rsD, rtD}).
REQ-016 Stall outputs SHALL be combinational with zero-cycle latency from the current entries and the D inputs:
- stallF = stallD = lu | bh | stallExt;
- flushE = (lu | bh) & ~stallExt.
REQ-017 Source register 0 SHALL never cause a hazard.
REQ-018 An invalid entry (valid=0) SHALL never cause a hazard.
REQ-019 regWriteX SHALL equal valid_X & regWrite_X. writeRegX SHALL equal dest_X.
REQ-020 A two-cycle branch hazard (producer in E, then a load in M) SHALL produce back-to-back stall cycles without any Decode input changes.

Reset
REQ-021 While rst=0 at a clk edge, all entries SHALL clear to zero, overriding stallExt. On the following cycle all outputs SHALL be 0 unless stallExt=1.
REQ-022 Reset asserted in the middle of a stall SHALL discard all tracked producers. No hazard SHALL be reported from pre-reset state.

Configuration
REQ-023 Macro HAZARD_TRACKER_STATS_EN SHALL control the stall counter.
- Defined: add output stallCount[15:0], reset to 0, incremented on each clk edge where lu|bh=1 and stallExt=0, saturating at 16'hFFFF.
- Undefined: the port and the counter SHALL not exist.

Structure
REQ-024 A shared package SHALL hold:
- REG_W=5;
- REG_ZERO=5'd0;
- the entry struct typedef {valid, regWrite, memToReg, dest};
- STATS_W=16.
REQ-025 One sub-module, hazard_stage_reg, SHALL implement a single entry with load, hold, bubble and clear. It SHALL be instantiated three times.

Verification
REQ-026 Load-use: lw r5 in E, Decode rsD=5 -> one cycle of stallF=stallD=flushE=1, next cycle stall=0, and regWriteM=1 with writeRegM=5.
REQ-027 Zero register: lw r0 in E, rsD=0 -> no stall. Also, add writing r3 in E, not a load, with rsD=3 and branchD=0 -> no stall.
REQ-028 Branch: add r7 in E, beq rsD=7 in D -> stall 1 cycle. Then with lw r7 in M, beq rtD=7 -> one more stall cycle; the third cycle is clear.
REQ-029 stallExt=1 during a load-use hazard -> stallF=1, flushE=0, entries unchanged for 3 cycles. On release -> one bubble, then resume.
REQ-030 rst=0 with lw r9 in E -> the next cycle has rsD=9 and no stall, with all writeRegX=0.
REQ-031 With HAZARD_TRACKER_STATS_EN defined: 70000 forced load-use cycles -> stallCount=16'hFFFF, with no wrap.
